ibex_dmem_bridge: RTL and testbench

Bridges the Ibex LSU data interface (req/gnt/rvalid, byte addresses) to the single-port SRAM data-memory model's sram_* handshake (word addresses, two-phase gnt). Sits directly upstream of the data memory, between the core top and the SRAM. Provides one outstanding access, address range checking with error responses, and a byte address output for the contract checker.

---
 rtl/ibex_dmem_pkg.sv | 17 +
 rtl/ibex_dmem_bridge_if.sv | 24 ++
 rtl/ibex_dmem_addr_chk.sv | 23 ++
 rtl/ibex_dmem_bridge.sv | 140 ++++++++++++++
 tb/tb_ibex_dmem_bridge.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_dmem_pkg.sv
// rtl/ibex_dmem_pkg.sv - shared state encoding and sizing constants for the Ibex data-memory bridge
package ibex_dmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RV,
    RESP,
    ERR
  } dmem_state_e;

  localparam int unsigned DMEM_WORD_BYTES        = 4;
  localparam int unsigned DMEM_WORD_SHIFT        = $clog2(DMEM_WORD_BYTES);
  localparam int unsigned DMEM_DEFAULT_DEPTH     = 1024;
  localparam logic [31:0] DMEM_DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/ibex_dmem_bridge_if.sv
// rtl/ibex_dmem_bridge_if.sv - Ibex LSU data-port handshake (req/gnt/rvalid) between core and bridge
interface ibex_dmem_bridge_if;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

endinterface

// File: rtl/ibex_dmem_addr_chk.sv
// rtl/ibex_dmem_addr_chk.sv - byte address to SRAM word index translation with in-range flag
module ibex_dmem_addr_chk
  import ibex_dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = DMEM_DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = DMEM_DEFAULT_BASE_ADDR,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] word_idx,
  output logic          in_range
);

  logic [31:0] offset;
  logic [31:0] word;

  // The byte-offset bits fall away in the shift; the LSU only issues aligned accesses.
  assign offset   = addr - BASE_ADDR;
  assign word     = offset >> DMEM_WORD_SHIFT;
  assign word_idx = word[AW-1:0];
  assign in_range = (addr >= BASE_ADDR) && (word < DEPTH);

endmodule

// File: rtl/ibex_dmem_bridge.sv
// rtl/ibex_dmem_bridge.sv - single-outstanding LSU to SRAM bridge with range errors
// Optional SRAM handshake timeout enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module ibex_dmem_bridge
  import ibex_dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = DMEM_DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR      = DMEM_DEFAULT_BASE_ADDR,
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 16,
`endif
  localparam int unsigned AW            = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_dmem_bridge_if.slave    lsu,
  output logic                 sram_req_o,
  input  logic                 sram_gnt_i,
  input  logic                 sram_rvalid_i,
  output logic                 sram_we_o,
  output logic [3:0]           sram_be_o,
  output logic [AW-1:0]        sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  input  logic [31:0]          sram_rdata_i,
  output logic [31:0]          lsu_addr_ctr_o
);

  dmem_state_e   state_q;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          gnt;
  logic          timeout;
  logic          rvalid_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  ibex_dmem_addr_chk #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_chk (
    .addr     (lsu.data_addr_i),
    .word_idx (word_idx),
    .in_range (in_range)
  );

  assign gnt               = (state_q == IDLE) && lsu.data_req_i;
  assign lsu.data_gnt_o    = gnt;
  assign lsu.data_rvalid_o = rvalid_q;
  assign lsu.data_err_o    = err_q;
  assign lsu.data_rdata_o  = rdata_q;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  // Fires on the cycle that would make the wait TIMEOUT_CYCLES long, so ERR follows directly.
  assign timeout = (state_q == REQ || state_q == WAIT_RV) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (gnt) begin
      to_cnt_q <= '0;
    end else if (state_q == REQ || state_q == WAIT_RV) begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      sram_req_o     <= 1'b0;
      sram_we_o      <= 1'b0;
      sram_be_o      <= 4'h0;
      sram_addr_o    <= '0;
      sram_wdata_o   <= 32'h0;
      lsu_addr_ctr_o <= 32'h0;
      rvalid_q       <= 1'b0;
      err_q          <= 1'b0;
      rdata_q        <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lsu.data_req_i) begin
            sram_we_o      <= lsu.data_we_i;
            sram_be_o      <= lsu.data_be_i;
            sram_addr_o    <= word_idx;
            sram_wdata_o   <= lsu.data_wdata_i;
            lsu_addr_ctr_o <= lsu.data_addr_i;
            if (in_range) begin
              state_q    <= REQ;
              sram_req_o <= 1'b1;
            end else begin
              state_q  <= ERR;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= 32'h0;
            end
          end
        end
        REQ: begin
          if (timeout) begin
            state_q    <= ERR;
            sram_req_o <= 1'b0;
            rvalid_q   <= 1'b1;
            err_q      <= 1'b1;
            rdata_q    <= 32'h0;
          end else if (sram_gnt_i) begin
            // A same-cycle rvalid is deliberately not consumed here.
            state_q    <= WAIT_RV;
            sram_req_o <= 1'b0;
          end
        end
        WAIT_RV: begin
          if (timeout) begin
            state_q  <= ERR;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= 32'h0;
          end else if (sram_rvalid_i) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= sram_we_o ? 32'h0 : sram_rdata_i;
          end
        end
        RESP, ERR: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_dmem_bridge.sv
// tb/tb_ibex_dmem_bridge.sv - directed scoreboard bench for ibex_dmem_bridge with a two-phase SRAM model
module tb_ibex_dmem_bridge;

  logic        clk;
  logic        rst_n;
  logic        sram_req_o;
  logic        sram_gnt_i;
  logic        sram_rvalid_i;
  logic        sram_we_o;
  logic [3:0]  sram_be_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;
  logic [31:0] lsu_addr_ctr_o;

  ibex_dmem_bridge_if lsu ();

  ibex_dmem_bridge dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .lsu            (lsu),
    .sram_req_o     (sram_req_o),
    .sram_gnt_i     (sram_gnt_i),
    .sram_rvalid_i  (sram_rvalid_i),
    .sram_we_o      (sram_we_o),
    .sram_be_o      (sram_be_o),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .sram_rdata_i   (sram_rdata_i),
    .lsu_addr_ctr_o (lsu_addr_ctr_o)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          resp_cyc = 0;
  int          resp_count = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mem [0:1023];
  logic        hold_rv = 1'b0;
  logic        stray_rv = 1'b0;
  logic        gnt_tie0 = 1'b0;
  logic        m_clear = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // SRAM model: grants one cycle after it first sees a request, answers the cycle after the grant.
  initial begin
    logic        pend;
    logic [31:0] pend_data;
    int          age;
    pend = 1'b0; pend_data = 32'h0; age = 0;
    sram_gnt_i = 1'b0; sram_rvalid_i = 1'b0; sram_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      sram_gnt_i = 1'b0; sram_rvalid_i = 1'b0; sram_rdata_i = 32'h0;
      if (m_clear) begin pend = 1'b0; age = 0; end
      if (pend && !hold_rv) begin
        sram_rvalid_i = 1'b1; sram_rdata_i = pend_data; pend = 1'b0;
      end else if (stray_rv) begin
        sram_rvalid_i = 1'b1; sram_rdata_i = 32'hBAD0_BAD0;
      end
      if (sram_req_o && !m_clear) begin
        if (age >= 1 && !gnt_tie0) begin
          sram_gnt_i = 1'b1;
          if (sram_we_o)
            mem[sram_addr_o] = (mem[sram_addr_o] & ~be_mask(sram_be_o)) | (sram_wdata_o & be_mask(sram_be_o));
          pend_data = mem[sram_addr_o] & be_mask(sram_be_o);
          pend = 1'b1; age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Response scoreboard: every rvalid pops one expectation.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && lsu.data_rvalid_o) begin
        resp_cyc = cyc;
        resp_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rdata", lsu.data_rdata_o, e[31:0]);
          chk("err", 32'(lsu.data_err_o), 32'(e[32]));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                       input logic push, input logic [31:0] er, input logic ee, output int g);
    lsu.data_req_i = 1'b1; lsu.data_addr_i = a; lsu.data_we_i = we;
    lsu.data_be_i = be; lsu.data_wdata_i = wd;
    g = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lsu.data_gnt_o) begin g = cyc; break; end
    end
    chk("gnt_seen", 32'(g >= 0), 32'(1));
    if (push && g >= 0) exp_q.push_back({ee, er});
    @(posedge clk); #1;
    lsu.data_req_i = 1'b0;
  endtask

  task automatic wait_resp(input int g, input int lat, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    chk({tag, "_done"}, 32'(exp_q.size()), 32'(0));
    chk(tag, 32'(resp_cyc - g), 32'(lat));
  endtask

  initial begin
    int g, g1, g2, cnt_before;
    lsu.data_req_i = 1'b0; lsu.data_we_i = 1'b0; lsu.data_be_i = 4'h0;
    lsu.data_addr_i = 32'h0; lsu.data_wdata_i = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[4] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sram_req", 32'(sram_req_o), 32'(0));
    chk("rst_rvalid", 32'(lsu.data_rvalid_o), 32'(0));
    chk("rst_err", 32'(lsu.data_err_o), 32'(0));
    chk("rst_rdata", lsu.data_rdata_o, 32'h0);
    chk("rst_gnt", 32'(lsu.data_gnt_o), 32'(0));
    chk("rst_sram_fields", {sram_wdata_o[15:0], 1'b0, sram_we_o, sram_be_o, sram_addr_o}, 32'h0);
    chk("rst_addr_ctr", lsu_addr_ctr_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal load
    issue(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, g);
    @(negedge clk);
    chk("load_sram_req", 32'(sram_req_o), 32'(1));
    chk("load_sram_addr", 32'(sram_addr_o), 32'(4));
    chk("load_sram_we", 32'(sram_we_o), 32'(0));
    chk("load_addr_ctr", lsu_addr_ctr_o, 32'h0000_0010);
    chk("load_gnt_busy", 32'(lsu.data_gnt_o), 32'(0));
    wait_resp(g, 4, "lat_load");

    // Partial store to the last word, then read it back
    issue(32'h0000_0FFC, 1'b1, 4'h3, 32'h1234_5678, 1'b1, 32'h0, 1'b0, g);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("store_sram_req", 32'(sram_req_o), 32'(1));
      chk("store_sram_we", 32'(sram_we_o), 32'(1));
      chk("store_sram_be", 32'(sram_be_o), 32'(3));
      chk("store_sram_addr", 32'(sram_addr_o), 32'(1023));
      chk("store_sram_wdata", sram_wdata_o, 32'h1234_5678);
    end
    wait_resp(g, 4, "lat_store");
    issue(32'h0000_0FFC, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_5678, 1'b0, g);
    wait_resp(g, 4, "lat_load_back");

    // Out-of-range load: immediate error, no SRAM access
    issue(32'h0000_1000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, g);
    @(negedge clk);
    chk("oor_no_sram_req", 32'(sram_req_o), 32'(0));
    wait_resp(g, 1, "lat_oor");

    // Request held high for two loads
    lsu.data_req_i = 1'b1; lsu.data_addr_i = 32'h0; lsu.data_we_i = 1'b0; lsu.data_be_i = 4'hF;
    g1 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lsu.data_gnt_o) begin g1 = cyc; break; end
    end
    exp_q.push_back({1'b0, 32'h1111_1111});
    @(posedge clk); #1;
    lsu.data_addr_i = 32'h4;
    g2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lsu.data_gnt_o) begin g2 = cyc; break; end
    end
    exp_q.push_back({1'b0, 32'h2222_2222});
    chk("b2b_gnt_gap", 32'(g2 - g1), 32'(5));
    @(posedge clk); #1;
    lsu.data_req_i = 1'b0;
    wait_resp(g2, 4, "lat_b2b");

    // Reset while waiting for rvalid
    hold_rv = 1'b1;
    issue(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, g);
    repeat (3) @(negedge clk);
    cnt_before = resp_count;
    rst_n = 1'b0; #1;
    chk("midrst_sram_req", 32'(sram_req_o), 32'(0));
    chk("midrst_addr_ctr", lsu_addr_ctr_o, 32'h0);
    chk("midrst_sram_addr", 32'(sram_addr_o), 32'(0));
    m_clear = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_clear = 1'b0; hold_rv = 1'b0;
    @(negedge clk); stray_rv = 1'b1;
    @(negedge clk); stray_rv = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_resp_after_rst", 32'(resp_count), 32'(cnt_before));
    @(posedge clk); #1;
    issue(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, g);
    wait_resp(g, 4, "lat_after_rst");

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    // SRAM never grants: the bridge gives up with an error
    gnt_tie0 = 1'b1;
    issue(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, g);
    wait_resp(g, 17, "lat_timeout");
    @(negedge clk);
    chk("timeout_req_low", 32'(sram_req_o), 32'(0));
    gnt_tie0 = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
